alu_dmem_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 16 +
 rtl/adder_32_bit.sv | 16 +
 rtl/alu_dmem_unit.sv | 104 ++++++++++
 tb/tb_alu_dmem_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and default sizing for the execute/memory slice.
// Pure declarations: no logic, no latency, no flow control.
// Imported by alu_dmem_unit and its testbench.
package alu_pkg;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_RAM_DEPTH = 256;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/adder_32_bit.sv
// Two-operand binary adder with carry in/out, shared by ADD, SUB and SLT.
// Latency: combinational, 0 cycles.
// Backpressure: none, output always valid.
module adder_32_bit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/alu_dmem_unit.sv
// Combinational ALU whose result addresses a byte-wide little-endian data RAM; ALU_OVERFLOW_EN adds an ovf port.
// Latency: ALU and load 0 cycles, store lands on the next rising clk edge.
// Backpressure: none, every operation completes in its own cycle.
module alu_dmem_unit
    import alu_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int RAM_DEPTH = DEFAULT_RAM_DEPTH,
    parameter int ADDR_BITS = $clog2(RAM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctr,
    input  logic             cs_ram,
    input  logic             we,
    input  logic             oe,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             cout,
    output logic [WIDTH-1:0] d_out
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int BYTES = WIDTH / 8;

    logic             use_sub;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum;
    logic             add_cout;
    logic             ovf_int;
    logic             adder_op;

    // SUB and SLT share the adder as a + ~b + 1.
    assign use_sub  = (alu_ctr == ALU_SUB) || (alu_ctr == ALU_SLT);
    assign adder_op = use_sub || (alu_ctr == ALU_ADD);
    assign op_b     = use_sub ? ~b : b;

    adder_32_bit #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (a),
        .b    (op_b),
        .cin  (use_sub),
        .sum  (sum),
        .cout (add_cout)
    );

    // Overflow judged on the operand actually fed to the adder, so SLT stays exact.
    assign ovf_int = (a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        y = '0;
        case (alu_ctr)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_ADD: y = sum;
            ALU_SUB: y = sum;
            ALU_SLT: y = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_int};
            ALU_NOR: y = ~(a | b);
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);
    assign cout = adder_op & add_cout;

`ifdef ALU_OVERFLOW_EN
    assign ovf = ovf_int && ((alu_ctr == ALU_ADD) || (alu_ctr == ALU_SUB));
`endif

    logic [7:0]           mem [RAM_DEPTH];
    logic [ADDR_BITS-3:0] word_base;

    // Low two address bits force word alignment; bits above ADDR_BITS wrap.
    assign word_base = y[ADDR_BITS-1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (cs_ram && we) begin
            for (int k = 0; k < BYTES; k++) begin
                mem[{word_base, k[1:0]}] <= d_in[8*k +: 8];
            end
        end
    end

    always_comb begin
        d_out = '0;
        if (cs_ram && oe) begin
            for (int k = 0; k < BYTES; k++) begin
                d_out[8*k +: 8] = mem[{word_base, k[1:0]}];
            end
        end
    end

endmodule

// File: tb/tb_alu_dmem_unit.sv
// Directed bench for alu_dmem_unit: ALU ops, adder edges, store/load, gating, addressing, reset.
module tb_alu_dmem_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b, d_in;
    logic [3:0]  alu_ctr;
    logic        cs_ram, we, oe;
    logic [31:0] y, d_out;
    logic        zero, cout;
`ifdef ALU_OVERFLOW_EN
    logic        ovf;
`endif

    logic [31:0] ad_a, ad_b, ad_sum;
    logic        ad_cin, ad_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_dmem_unit dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .alu_ctr (alu_ctr),
        .cs_ram  (cs_ram),
        .we      (we),
        .oe      (oe),
        .d_in    (d_in),
        .y       (y),
        .zero    (zero),
        .cout    (cout),
        .d_out   (d_out)
`ifdef ALU_OVERFLOW_EN
        ,
        .ovf     (ovf)
`endif
    );

    adder_32_bit u_adder_chk (
        .a    (ad_a),
        .b    (ad_b),
        .cin  (ad_cin),
        .sum  (ad_sum),
        .cout (ad_cout)
    );

    task automatic drive(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        alu_ctr = op;
        a       = va;
        b       = vb;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'hFC};
        cs_ram = 1'b1; oe = 1'b1; we = 1'b0;
        foreach (addrs[i]) begin
            drive(ALU_ADD, 32'h0, addrs[i]);
            checks++;
            if (d_out !== 32'h0) begin errors++; $display("FAIL reset_read addr=%h got %h want 0", addrs[i], d_out); end
        end
    endtask

    task automatic test_add();
        drive(ALU_ADD, 32'h0, 32'hFFFFFFFF);
        checks++;
        if (y !== 32'hFFFFFFFF || cout !== 1'b0 || zero !== 1'b0) begin errors++; $display("FAIL add_0_ffff y=%h cout=%b zero=%b want ffffffff 0 0", y, cout, zero); end
        drive(ALU_ADD, 32'h7FFFFFFF, 32'h7FFFFFFF);
        checks++;
        if (y !== 32'hFFFFFFFE || cout !== 1'b0) begin errors++; $display("FAIL add_ovf y=%h cout=%b want fffffffe 0", y, cout); end
`ifdef ALU_OVERFLOW_EN
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL add_ovf_flag got %b want 1", ovf); end
`endif
        drive(ALU_ADD, 32'h1C, 32'h8);
        checks++;
        if (y !== 32'h24) begin errors++; $display("FAIL add_1c_8 got %h want 24", y); end
    endtask

    task automatic test_adder_direct();
        @(negedge clk);
        ad_a = 32'h0; ad_b = 32'hFFFFFFFF; ad_cin = 1'b1;
        #1;
        checks++;
        if (ad_sum !== 32'h0 || ad_cout !== 1'b1) begin errors++; $display("FAIL adder_cin sum=%h cout=%b want 0 1", ad_sum, ad_cout); end
    endtask

    task automatic test_alu_ops();
        drive(ALU_OR, 32'h0, 32'hC);
        checks++;
        if (y !== 32'hC || cout !== 1'b0) begin errors++; $display("FAIL or got %h cout=%b want c 0", y, cout); end
        drive(ALU_SUB, 32'hC, 32'h8);
        checks++;
        if (y !== 32'h4 || cout !== 1'b1) begin errors++; $display("FAIL sub got %h cout=%b want 4 1", y, cout); end
`ifdef ALU_OVERFLOW_EN
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL sub_ovf got %b want 0", ovf); end
`endif
        drive(ALU_AND, 32'h8, 32'hC);
        checks++;
        if (y !== 32'h8) begin errors++; $display("FAIL and got %h want 8", y); end
        drive(ALU_SLT, 32'hC, 32'hC);
        checks++;
        if (y !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL slt_eq y=%h zero=%b want 0 1", y, zero); end
        drive(ALU_SLT, 32'hFFFFFFFF, 32'h1);
        checks++;
        if (y !== 32'h1 || zero !== 1'b0) begin errors++; $display("FAIL slt_neg y=%h zero=%b want 1 0", y, zero); end
        drive(ALU_SLT, 32'h7FFFFFFF, 32'h80000000);
        checks++;
        if (y !== 32'h0) begin errors++; $display("FAIL slt_ovf got %h want 0", y); end
        drive(ALU_NOR, 32'h8, 32'hC);
        checks++;
        if (y !== 32'hFFFFFFF3) begin errors++; $display("FAIL nor got %h want fffffff3", y); end
        drive(4'b1111, 32'h1234, 32'h5678);
        checks++;
        if (y !== 32'h0 || zero !== 1'b1 || cout !== 1'b0) begin errors++; $display("FAIL undef_op y=%h zero=%b cout=%b want 0 1 0", y, zero, cout); end
    endtask

    task automatic test_store_load();
        cs_ram = 1'b1; oe = 1'b0;
        for (int i = 0; i <= 30; i++) begin
            drive(ALU_ADD, 32'h0, 32'(i * 4));
            d_in = 32'(i);
            we   = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        we = 1'b0; oe = 1'b1;
        for (int i = 0; i <= 30; i++) begin
            drive(ALU_ADD, 32'h0, 32'(i * 4));
            checks++;
            if (d_out !== 32'(i)) begin errors++; $display("FAIL sweep_read addr=%h got %h want %h", i * 4, d_out, i); end
        end
    endtask

    task automatic test_gating();
        cs_ram = 1'b1; we = 1'b0; oe = 1'b0;
        drive(ALU_ADD, 32'h0, 32'h8);
        checks++;
        if (d_out !== 32'h0) begin errors++; $display("FAIL gate_oe got %h want 0", d_out); end
        oe = 1'b1; cs_ram = 1'b0;
        #1;
        checks++;
        if (d_out !== 32'h0) begin errors++; $display("FAIL gate_cs got %h want 0", d_out); end
        we = 1'b1; d_in = 32'hFFFF0000;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0; cs_ram = 1'b1;
        #1;
        checks++;
        if (d_out !== 32'h2) begin errors++; $display("FAIL gate_we_no_cs got %h want 2", d_out); end
    endtask

    task automatic test_addressing();
        cs_ram = 1'b1; oe = 1'b0;
        drive(ALU_ADD, 32'h0, 32'h5);
        d_in = 32'h11223344; we = 1'b1;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0; oe = 1'b1;
        drive(ALU_ADD, 32'h0, 32'h4);
        checks++;
        if (d_out !== 32'h11223344) begin errors++; $display("FAIL align_read got %h want 11223344", d_out); end
        checks++;
        if (d_out[7:0] !== 8'h44) begin errors++; $display("FAIL byte4 got %h want 44", d_out[7:0]); end
        drive(ALU_ADD, 32'h100, 32'h7);
        checks++;
        if (d_out !== 32'h11223344) begin errors++; $display("FAIL wrap_read got %h want 11223344", d_out); end
    endtask

    task automatic test_back_to_back();
        cs_ram = 1'b1; oe = 1'b1; we = 1'b0;
        drive(ALU_ADD, 32'h0, 32'hC);
        d_in = 32'hAABBCCDD; we = 1'b1;
        #1;
        checks++;
        if (d_out !== 32'h3) begin errors++; $display("FAIL rw_before_edge got %h want 3", d_out); end
        @(posedge clk);
        #1;
        checks++;
        if (d_out !== 32'hAABBCCDD) begin errors++; $display("FAIL rw_after_edge got %h want aabbccdd", d_out); end
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_reset_clears();
        logic [31:0] addrs [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        cs_ram = 1'b1; oe = 1'b1;
        drive(ALU_ADD, 32'h0, 32'h8);
        d_in = 32'hDEADBEEF; we = 1'b1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; we = 1'b0;
        foreach (addrs[i]) begin
            drive(ALU_ADD, 32'h0, addrs[i]);
            checks++;
            if (d_out !== 32'h0) begin errors++; $display("FAIL post_reset addr=%h got %h want 0", addrs[i], d_out); end
        end
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; d_in = '0; alu_ctr = ALU_AND;
        cs_ram = 1'b0; we = 1'b0; oe = 1'b0;
        ad_a = '0; ad_b = '0; ad_cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_add();
        test_adder_direct();
        test_alu_ops();
        test_store_load();
        test_gating();
        test_addressing();
        test_back_to_back();
        test_reset_clears();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
